// File: rtl/lfsr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_ctrl_pkg
// Shared definitions for the 4-bit LFSR run controller:
//   - FSM state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3)
//   - LFSR width, tap mask for x^4+x^3+1 and the sequence period
//   - helper functions for the LFSR step and the period-step test
// ---------------------------------------------------------------------------
package lfsr_ctrl_pkg;

    localparam int unsigned LFSR_WIDTH = 4;
    localparam logic [3:0]  TAP_MASK   = 4'b1100;
    localparam int unsigned PERIOD     = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Feedback for x^4+x^3+1: XOR of the bits selected by TAP_MASK (out[3]^out[2]).
    function automatic logic lfsr_fb(input logic [3:0] v);
        return ^(v & TAP_MASK);
    endfunction

    // One Fibonacci shift-left step with the feedback entering at bit 0.
    function automatic logic [3:0] lfsr_next(input logic [3:0] v);
        return {v[2:0], lfsr_fb(v)};
    endfunction

    // True for the step counts at which a maximal-length sequence returns to its seed.
    function automatic logic is_period_step(input logic [4:0] cnt);
        return (cnt == 5'(PERIOD)) || (cnt == 5'(2 * PERIOD));
    endfunction

endpackage

// File: rtl/lfsr4_core.sv
// ---------------------------------------------------------------------------
// lfsr4_core
// 4-bit LFSR register (x^4+x^3+1) with parallel load and single-step enable.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-high reset, clears the register
//   load     - load load_val into the register (priority over step)
//   load_val - value to load
//   step     - advance the LFSR by one step
//   out      - current register value
//   fb_bit   - combinational feedback bit of the current value
// ---------------------------------------------------------------------------
module lfsr4_core
    import lfsr_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [LFSR_WIDTH-1:0] load_val,
    input  logic                  step,
    output logic [LFSR_WIDTH-1:0] out,
    output logic                  fb_bit
);

    logic [LFSR_WIDTH-1:0] r_lfsr;

    // LFSR register: load wins over step, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= 4'b0000;
        end else if (load) begin
            r_lfsr <= load_val;
        end else if (step) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end else begin
            r_lfsr <= r_lfsr;
        end
    end

    assign out    = r_lfsr;
    assign fb_bit = lfsr_fb(r_lfsr);

endmodule

// File: rtl/lfsr_run_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_run_ctrl
// Runs a 4-bit LFSR for a requested number of steps from a captured seed,
// flagging a zero seed, each return to the seed (wrap) and any wrap that
// does not line up with the 15-step period.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-high reset
//   start      - run request, sampled only in IDLE
//   abort      - cancel, sampled in LOAD and RUN
//   seed       - initial LFSR value, captured with start
//   num_steps  - number of steps to run (0..31), captured with start
//   out        - current LFSR state
//   fb_bit     - combinational feedback bit (out[3]^out[2])
//   busy       - high whenever the FSM is not IDLE
//   done       - one-cycle pulse on normal completion
//   seed_err   - one-cycle pulse with done when the captured seed is zero
//   wrap       - one-cycle pulse after a step that returns out to the seed
//   period_err - sticky; cleared on the next accepted start
// ---------------------------------------------------------------------------
module lfsr_run_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  seed,
    input  logic [STEP_W-1:0] num_steps,
    output logic [WIDTH-1:0]  out,
    output logic              fb_bit,
    output logic              busy,
    output logic              done,
    output logic              seed_err,
    output logic              wrap,
    output logic              period_err
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_seed;
    logic [STEP_W-1:0]  r_num_steps;
    logic [STEP_W-1:0]  r_step_cnt;
    logic               r_done;
    logic               r_seed_err;
    logic               r_wrap;
    logic               r_period_err;

    logic [WIDTH-1:0]   w_out;
    logic               w_fb;
    logic               w_load;
    logic               w_step;
    logic [WIDTH-1:0]   w_next_out;
    logic [STEP_W-1:0]  w_cnt_inc;
    logic               w_hit;

    // A zero seed skips the load so out keeps its previous value.
    assign w_load     = (r_state == ST_LOAD) && !abort && (r_seed != {WIDTH{1'b0}});
    assign w_step     = (r_state == ST_RUN) && !abort;
    assign w_next_out = {w_out[WIDTH-2:0], w_fb};
    assign w_cnt_inc  = r_step_cnt + STEP_W'(1);
    assign w_hit      = (w_next_out == r_seed);

    lfsr4_core u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (r_seed),
        .step     (w_step),
        .out      (w_out),
        .fb_bit   (w_fb)
    );

    // Control FSM with captured run parameters, step counter and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_seed       <= {WIDTH{1'b0}};
            r_num_steps  <= {STEP_W{1'b0}};
            r_step_cnt   <= {STEP_W{1'b0}};
            r_done       <= 1'b0;
            r_seed_err   <= 1'b0;
            r_wrap       <= 1'b0;
            r_period_err <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_seed_err <= 1'b0;
            r_wrap     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // start beats a simultaneous abort here
                    if (start) begin
                        r_state      <= ST_LOAD;
                        r_seed       <= seed;
                        r_num_steps  <= num_steps;
                        r_step_cnt   <= {STEP_W{1'b0}};
                        r_period_err <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    r_step_cnt <= {STEP_W{1'b0}};
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (r_seed == {WIDTH{1'b0}}) begin
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_seed_err <= 1'b1;
                    end else if (r_num_steps == {STEP_W{1'b0}}) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_step_cnt <= w_cnt_inc;
                        r_wrap     <= w_hit;
                        // Wrap off-period, or a period step without wrap, is an error.
                        if (w_hit != is_period_step(w_cnt_inc)) begin
                            r_period_err <= 1'b1;
                        end else begin
                            r_period_err <= r_period_err;
                        end
                        if (w_cnt_inc == r_num_steps) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out        = w_out;
    assign fb_bit     = w_fb;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign seed_err   = r_seed_err;
    assign wrap       = r_wrap;
    assign period_err = r_period_err;

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lfsr_run_ctrl
// Table-driven directed vectors plus hand-written multi-cycle sequences
// for the LFSR run controller.
// ---------------------------------------------------------------------------
module tb_lfsr_run_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] seed;
    logic [4:0] num_steps;
    logic [3:0] out;
    logic       fb_bit;
    logic       busy;
    logic       done;
    logic       seed_err;
    logic       wrap;
    logic       period_err;

    int n_checks = 0;
    int n_errors = 0;

    lfsr_run_ctrl #(.WIDTH(4), .STEP_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .seed       (seed),
        .num_steps  (num_steps),
        .out        (out),
        .fb_bit     (fb_bit),
        .busy       (busy),
        .done       (done),
        .seed_err   (seed_err),
        .wrap       (wrap),
        .period_err (period_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       abort;
        logic [3:0] seed;
        logic [4:0] num;
        logic [3:0] e_out;
        logic       e_busy;
        logic       e_done;
        logic       e_serr;
        logic       e_wrap;
    } vec_t;

    vec_t vecs[19];

    // Reference step for x^4+x^3+1, written directly from the polynomial.
    function automatic logic [3:0] model_step(input logic [3:0] v);
        return {v[2:0], v[3] ^ v[2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input logic ab, input logic [3:0] sd,
                                input logic [4:0] n, input logic [3:0] eo, input logic eb,
                                input logic ed, input logic es, input logic ew);
        vec_t v;
        v.start = st; v.abort = ab; v.seed = sd; v.num = n;
        v.e_out = eo; v.e_busy = eb; v.e_done = ed; v.e_serr = es; v.e_wrap = ew;
        return v;
    endfunction

    logic [3:0] m;
    int         wrap_cnt;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; seed = 4'b0000; num_steps = 5'd0;

        //            start abort seed     N      out      busy  done  serr  wrap
        // zero seed: done + seed_err two cycles after start, out untouched
        vecs[0]  = mk(1'b1, 1'b0, 4'b0000, 5'd5,  4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 4'b0000, 5'd0,  4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 4'b0000, 5'd0,  4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        // seed 1001, N=3
        vecs[3]  = mk(1'b1, 1'b0, 4'b1001, 5'd3,  4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 4'b0000, 5'd0,  4'b1001, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 4'b0000, 5'd0,  4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 4'b0000, 5'd0,  4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 4'b0000, 5'd0,  4'b1101, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 4'b0000, 5'd0,  4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
        // seed 1001, N=0; restarts in LOAD and DONE are ignored
        vecs[9]  = mk(1'b1, 1'b0, 4'b1001, 5'd0,  4'b1101, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 4'b0110, 5'd7,  4'b1001, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 4'b0110, 5'd7,  4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 4'b0000, 5'd0,  4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
        // abort in LOAD
        vecs[13] = mk(1'b1, 1'b0, 4'b0110, 5'd4,  4'b1001, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 1'b1, 4'b0000, 5'd0,  4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
        // start and abort together in IDLE: start wins; N=1
        vecs[15] = mk(1'b1, 1'b1, 4'b0110, 5'd1,  4'b1001, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[16] = mk(1'b0, 1'b0, 4'b0000, 5'd0,  4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[17] = mk(1'b0, 1'b0, 4'b0000, 5'd0,  4'b1101, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[18] = mk(1'b0, 1'b0, 4'b0000, 5'd0,  4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        #12;
        check("rst_out", 32'(out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_serr", 32'(seed_err), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        check("rst_perr", 32'(period_err), 32'h0);
        check("rst_fb", 32'(fb_bit), 32'h0);
        reset = 1'b0;
        #1;

        // Table-driven vectors
        for (int i = 0; i < 19; i++) begin
            start = vecs[i].start; abort = vecs[i].abort;
            seed = vecs[i].seed; num_steps = vecs[i].num;
            tick();
            check($sformatf("v%0d_out", i), 32'(out), 32'(vecs[i].e_out));
            check($sformatf("v%0d_fb", i), 32'(fb_bit), 32'(vecs[i].e_out[3] ^ vecs[i].e_out[2]));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].e_done));
            check($sformatf("v%0d_serr", i), 32'(seed_err), 32'(vecs[i].e_serr));
            check($sformatf("v%0d_wrap", i), 32'(wrap), 32'(vecs[i].e_wrap));
            check($sformatf("v%0d_perr", i), 32'(period_err), 32'h0);
        end
        start = 1'b0; abort = 1'b0;

        // Seed 1001, N=31: wrap at steps 15 and 30 only, final 0011
        start = 1'b1; seed = 4'b1001; num_steps = 5'd31;
        tick();
        start = 1'b0;
        tick();
        check("n31_load", 32'(out), 32'h9);
        m = 4'b1001;
        wrap_cnt = 0;
        for (int s = 1; s <= 31; s++) begin
            tick();
            m = model_step(m);
            check($sformatf("n31_s%0d_out", s), 32'(out), 32'(m));
            check($sformatf("n31_s%0d_wrap", s), 32'(wrap), 32'((s == 15) || (s == 30)));
            check($sformatf("n31_s%0d_done", s), 32'(done), 32'(s == 31));
            if (wrap) wrap_cnt++;
        end
        check("n31_final", 32'(out), 32'h3);
        check("n31_wraps", 32'(wrap_cnt), 32'd2);
        check("n31_perr", 32'(period_err), 32'h0);
        tick();
        check("n31_idle", 32'(busy), 32'h0);

        // Seed 1101, N=20, abort after step 5
        start = 1'b1; seed = 4'b1101; num_steps = 5'd20;
        tick();
        start = 1'b0;
        tick();
        check("ab_load", 32'(out), 32'hD);
        for (int s = 1; s <= 5; s++) tick();
        check("ab_s5_out", 32'(out), 32'hF);
        check("ab_s5_busy", 32'(busy), 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", 32'(busy), 32'h0);
        check("ab_done", 32'(done), 32'h0);
        check("ab_out", 32'(out), 32'hF);
        tick();
        check("ab_hold_out", 32'(out), 32'hF);
        check("ab_hold_done", 32'(done), 32'h0);
        check("ab_perr", 32'(period_err), 32'h0);

        // Asynchronous reset mid-RUN
        start = 1'b1; seed = 4'b1001; num_steps = 5'd10;
        tick();
        start = 1'b0;
        tick();
        tick(); tick(); tick();
        check("ar_pre_out", 32'(out), 32'hD);
        #2;
        reset = 1'b1;
        #1;
        check("ar_out", 32'(out), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        check("ar_done", 32'(done), 32'h0);
        check("ar_fb", 32'(fb_bit), 32'h0);
        #2;
        reset = 1'b0;
        // first start after reset accepted on the next edge
        start = 1'b1; seed = 4'b0110; num_steps = 5'd2;
        tick();
        start = 1'b0;
        check("ar_restart_busy", 32'(busy), 32'h1);
        tick();
        check("ar_restart_load", 32'(out), 32'h6);
        tick();
        check("ar_s1", 32'(out), 32'hD);
        check("ar_s1_done", 32'(done), 32'h0);
        tick();
        check("ar_s2", 32'(out), 32'hA);
        check("ar_s2_done", 32'(done), 32'h1);
        tick();
        check("ar_end_busy", 32'(busy), 32'h0);
        check("ar_end_done", 32'(done), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lfsr_run_ctrl.md
LFSR_RUN_CTRL -- requirements
Module: lfsr_run_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, LFSR register width; only 4 is supported.
REQ-002 Parameter STEP_W, default 5, width of the step-count request.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 abort  input  1  cancel the current run; sampled in LOAD and RUN.
REQ-007 seed  input  4  initial LFSR value; captured on the accepted start edge.
REQ-008 num_steps  input  5  number of LFSR steps (0..31); captured with seed.
REQ-009 out  output  4  current LFSR state.
REQ-010 fb_bit  output  1  feedback bit, combinational: out[3]^out[2].
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 done  output  1  one-cycle pulse marking normal run completion.
REQ-013 seed_err  output  1  one-cycle pulse, coincident with done, when the captured seed is 0000.
REQ-014 wrap  output  1  one-cycle pulse in any RUN cycle where out equals the captured seed after at least one step.
REQ-015 period_err  output  1  sticky error flag; cleared on the next accepted start.

Function
REQ-016 States SHALL be IDLE, LOAD, RUN and DONE.
REQ-017 Transition IDLE->LOAD on an edge with start=1; seed and num_steps SHALL be registered on that edge.
REQ-018 Transition LOAD->DONE on the next edge if the captured seed is zero; seed_err SHALL assert and out SHALL stay unchanged.
REQ-019 Otherwise, on the LOAD->RUN edge, out SHALL load the seed; if num_steps=0 the transition is LOAD->DONE, with out still loaded.
REQ-020 Each RUN edge SHALL perform one step: out <= {out[2:0], out[3]^out[2]}, polynomial x^4+x^3+1, and increment step_cnt.
REQ-021 The RUN->DONE transition SHALL occur on the edge performing step N = num_steps; exactly N steps occur.
REQ-022 done=1 throughout DONE (one cycle); DONE->IDLE is unconditional on the following edge.
REQ-023 Latency: with start accepted at edge k, done SHALL be high in the cycle after edge k+1+N (k+1 for N=0 or a zero seed).
REQ-024 Timing: wrap SHALL be registered alongside the step that produces out==seed.
REQ-025 period_err SHALL set if wrap occurs at a step count not equal to 15 or 30.
REQ-026 period_err SHALL also set if step 15 or 30 completes without wrap.
REQ-027 Abort in LOAD or RUN SHALL return the state to IDLE on the next edge: no done, out holds its last value, period_err unchanged.
REQ-028 Start while busy SHALL be ignored, with no queuing.
REQ-029 Abort and start in IDLE together: start wins and abort is ignored.
REQ-030 Outside RUN, out SHALL hold; in IDLE it holds the last result.
REQ-031 step_cnt SHALL be 5 bits, reset to 0 at LOAD, and never wrap within a run (max 31).

Reset
REQ-032 Reset SHALL force IDLE and zero out, step_cnt, captured seed and num_steps registers, done, seed_err, wrap and period_err.
REQ-033 Reset mid-run SHALL abandon the run immediately with no done pulse; fb_bit follows out (0).
REQ-034 After reset deassertion, the first start SHALL be accepted on the next edge.

Structure
REQ-035 The shared package lfsr_ctrl_pkg SHALL hold the state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3), LFSR_WIDTH=4, TAP_MASK=4'b1100 and PERIOD=15.
REQ-036 The LFSR register and feedback SHALL be a sub-module lfsr4_core (ports: clk, reset, load, load_val, step, out, fb_bit); lfsr_run_ctrl holds the FSM, counters and checks.

Verification
REQ-037 Seed 1001, N=3: out SHALL be 1001, 0011, 0110, 1101 on successive edges; done pulses once; busy falls after DONE; seed_err=0.
REQ-038 Seed 0000, N=5: seed_err and done SHALL pulse together 2 cycles after start; out stays 0000; no RUN cycles occur.
REQ-039 Seed 1001, N=31: wrap SHALL pulse at steps 15 and 30 only; period_err=0; final out = 0011.
REQ-040 Seed 1101, N=20, abort after step 5: IDLE on the next edge, no done, out holds the step-5 value, busy=0.
REQ-041 Seed 1001, N=0: out=1001 and done SHALL be high in the cycle after edge k+1; a second start during LOAD SHALL be ignored.
REQ-042 Reset asserted asynchronously mid-RUN: out=0000, busy=0 and done=0 SHALL hold immediately, without waiting for a clock edge.
